// File: rtl/tap_window_sum.sv
// Sums the three taps of an upstream nibble shift chain, tracks how many
// fresh samples the window holds, and counts rising threshold crossings.
module tap_window_sum #(
    parameter logic [5:0] THRESH = 6'd24,
    parameter int         CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Ce,
    input  logic [3:0]       Dout1,
    input  logic [3:0]       Dout2,
    input  logic [3:0]       Dout,
    input  logic             Clr,
    output logic [5:0]       Sum,
    output logic             Valid,
    output logic             Over,
    output logic             Hit,
    output logic [CNT_W-1:0] HitCnt
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO,
        FULL
    } fill_t;

    fill_t            r_state;
    logic             r_ced;
    logic [5:0]       r_sum;
    logic             r_valid;
    logic             r_over;
    logic             r_hit;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0]       w_sum;
    logic             w_valid_nxt;
    logic             w_over_nxt;
    logic             w_rise;

    assign w_sum       = {2'b00, Dout1} + {2'b00, Dout2} + {2'b00, Dout};
    // The third fresh sample arrives on the update that leaves TWO.
    assign w_valid_nxt = r_valid | (r_state == TWO) | (r_state == FULL);
    assign w_over_nxt  = w_valid_nxt & (w_sum > THRESH);
    assign w_rise      = r_ced & w_over_nxt & ~r_over;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= EMPTY;
            r_ced   <= 1'b0;
            r_sum   <= '0;
            r_valid <= 1'b0;
            r_over  <= 1'b0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
        end else if (Clr) begin
            r_state <= EMPTY;
            r_ced   <= 1'b0;
            r_sum   <= '0;
            r_valid <= 1'b0;
            r_over  <= 1'b0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_ced <= Ce;
            r_hit <= w_rise;
            if (w_rise && !(&r_cnt))
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_ced) begin
                r_sum   <= w_sum;
                r_valid <= w_valid_nxt;
                r_over  <= w_over_nxt;
                case (r_state)
                    EMPTY:   r_state <= ONE;
                    ONE:     r_state <= TWO;
                    default: r_state <= FULL;
                endcase
            end
        end
    end

    assign Sum    = r_sum;
    assign Valid  = r_valid;
    assign Over   = r_over;
    assign Hit    = r_hit;
    assign HitCnt = r_cnt;

endmodule

// File: tb/tb_tap_window_sum.sv
// Directed bench for tap_window_sum: models the upstream 3-stage nibble chain
// and checks fill, threshold, saturation, clear and async reset behaviour.
module tb_tap_window_sum;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Ce  = 1'b0;
    logic       Clr = 1'b0;
    logic [3:0] Din = '0;
    logic [3:0] d1, d2, d3;

    logic [5:0] sum_a, sum_b;
    logic       valid_a, valid_b, over_a, over_b, hit_a, hit_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    // Upstream chain: shared Ce, never touched by Clr.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (Ce) begin
            d1 <= Din;
            d2 <= d1;
            d3 <= d2;
        end
    end

    tap_window_sum #(.THRESH(6'd24), .CNT_W(8)) u_dut_a (
        .CLK(CLK), .RST(RST), .Ce(Ce), .Dout1(d1), .Dout2(d2), .Dout(d3),
        .Clr(Clr), .Sum(sum_a), .Valid(valid_a), .Over(over_a), .Hit(hit_a),
        .HitCnt(cnt_a)
    );

    tap_window_sum #(.THRESH(6'd24), .CNT_W(2)) u_dut_b (
        .CLK(CLK), .RST(RST), .Ce(Ce), .Dout1(d1), .Dout2(d2), .Dout(d3),
        .Clr(Clr), .Sum(sum_b), .Valid(valid_b), .Over(over_b), .Hit(hit_b),
        .HitCnt(cnt_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One Ce pulse, then wait for the Sum update two edges later.
    task automatic shift(input logic [3:0] v);
        Din = v;
        Ce  = 1'b1;
        @(posedge CLK); #1;
        Ce  = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic pulse_clr();
        Clr = 1'b1;
        @(posedge CLK); #1;
        Clr = 1'b0;
    endtask

    int hits;
    int low_over;

    initial begin
        #1;
        chk("rst_sum",   int'(sum_a),   0);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_cnt",   int'(cnt_a),   0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Fill 1,2,3
        shift(4'd1);
        chk("fill1_sum",   int'(sum_a),   1);
        chk("fill1_valid", int'(valid_a), 0);
        shift(4'd2);
        chk("fill2_sum",   int'(sum_a),   3);
        chk("fill2_valid", int'(valid_a), 0);
        shift(4'd3);
        chk("fill3_sum",   int'(sum_a),   6);
        chk("fill3_valid", int'(valid_a), 1);
        chk("fill3_over",  int'(over_a),  0);

        // Threshold crossing 8,8,9 = 25
        shift(4'd8);
        chk("thr_sum13", int'(sum_a), 13);
        shift(4'd8);
        shift(4'd9);
        chk("thr_sum25", int'(sum_a), 25);
        chk("thr_over",  int'(over_a), 1);
        chk("thr_hit",   int'(hit_a),  1);
        chk("thr_cnt",   int'(cnt_a),  1);
        @(posedge CLK); #1;
        chk("thr_hit_drop",  int'(hit_a),  0);
        chk("thr_over_hold", int'(over_a), 1);
        shift(4'd8);
        shift(4'd8);
        chk("thr_rehit", int'(hit_a), 0);
        shift(4'd8);
        chk("eq_sum24", int'(sum_a),  24);
        chk("eq_over",  int'(over_a), 0);
        chk("eq_hit",   int'(hit_a),  0);
        chk("eq_cnt",   int'(cnt_a),  1);

        // Sustained 15s with Ce held high
        hits = 0;
        low_over = 0;
        Din = 4'd15;
        Ce  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            hits += int'(hit_a);
            if (i >= 1 && !over_a) low_over++;
            if (i == 3) chk("sus_sum_edge4", int'(sum_a), 45);
        end
        Ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            hits += int'(hit_a);
            if (!over_a) low_over++;
        end
        chk("sus_sum",      int'(sum_a), 45);
        chk("sus_hits",     hits,        1);
        chk("sus_over_low", low_over,    0);
        chk("sus_cnt",      int'(cnt_a), 2);

        // Saturation on the 2-bit counter: 5 crossings 30 / 10
        pulse_clr();
        chk("sat_clr_cnt", int'(cnt_b), 0);
        for (int k = 0; k < 5; k++) begin
            shift(4'd10);
            shift(4'd10);
            shift(4'd10);
            chk($sformatf("sat_over_%0d", k), int'(over_b), 1);
            shift(4'd3);
            shift(4'd3);
            shift(4'd4);
            chk($sformatf("sat_sum10_%0d", k), int'(sum_b), 10);
            chk($sformatf("sat_cntb_%0d", k), int'(cnt_b), (k + 1 > 3) ? 3 : k + 1);
            chk($sformatf("sat_cnta_%0d", k), int'(cnt_a), k + 1);
        end

        // Clr wins over simultaneous Ce while FULL
        Din = 4'd5;
        Ce  = 1'b1;
        Clr = 1'b1;
        @(posedge CLK); #1;
        Ce  = 1'b0;
        Clr = 1'b0;
        chk("clr_sum",   int'(sum_a),   0);
        chk("clr_valid", int'(valid_a), 0);
        chk("clr_cnt",   int'(cnt_a),   0);
        chk("clr_cntb",  int'(cnt_b),   0);
        @(posedge CLK); #1;
        chk("clr_ce_ignored", int'(sum_a), 0);
        shift(4'd1);
        chk("clr_f1_sum",   int'(sum_a),   10);
        chk("clr_f1_valid", int'(valid_a), 0);
        shift(4'd2);
        chk("clr_f2_valid", int'(valid_a), 0);
        shift(4'd3);
        chk("clr_f3_sum",   int'(sum_a),   6);
        chk("clr_f3_valid", int'(valid_a), 1);

        // Async reset while in TWO
        pulse_clr();
        shift(4'd4);
        shift(4'd4);
        chk("pre_rst_sum",   int'(sum_a),   11);
        chk("pre_rst_valid", int'(valid_a), 0);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_sum",   int'(sum_a),   0);
        chk("arst_valid", int'(valid_a), 0);
        chk("arst_over",  int'(over_a),  0);
        chk("arst_hit",   int'(hit_a),   0);
        @(posedge CLK); #1;
        RST = 1'b0;
        shift(4'd7);
        chk("rf1_sum",   int'(sum_a),   7);
        chk("rf1_valid", int'(valid_a), 0);
        shift(4'd7);
        chk("rf2_sum",   int'(sum_a),   14);
        chk("rf2_valid", int'(valid_a), 0);
        shift(4'd7);
        chk("rf3_sum",   int'(sum_a),   21);
        chk("rf3_valid", int'(valid_a), 1);
        chk("rf3_over",  int'(over_a),  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
